reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares one DATAWIDTH-bit storage register between NUMREQ requesters.
- Each cycle it selects at most one requesting source and loads that source's data word into the register.
- It returns a registered one-hot grant/acknowledge and the winner's index.
- Optional burst locking lets one requester hold the register for up to MAXBURST consecutive writes.
- Sits between datapath producers (ADD/SUB/MUL outputs) and a shared REG-style storage element.

Parameters:
DATAWIDTH, 8, width of each data word and of q
NUMREQ, 4, number of requesters (2..8)
IDXW, 2, width of owner index; must satisfy 2**IDXW >= NUMREQ
MAXBURST, 4, maximum consecutive writes granted to one locked requester (1..15)

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
req  input  NUMREQ  request bit per requester
lock  input  NUMREQ  per-requester burst-lock request; meaningful only together with req
d_bus  input  NUMREQ*DATAWIDTH  concatenated data words; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
q  output  DATAWIDTH  shared register contents
gnt  output  NUMREQ  registered one-hot grant; bit i high = requester i's word was loaded at the last edge
valid  output  1  high when q was written at the last edge
owner  output  IDXW  index of the last winner; holds its value when idle

Behaviour:
- Reset (Rst=1, asynchronous): q=0, gnt=0, valid=0, owner=0, ptr=0, bcnt=0, locked=0. All outputs take these values immediately on Rst assertion, independent of Clk.
- Internal state:
  - ptr: IDXW-bit round-robin start index.
  - bcnt: burst counter, 4 bits.
  - locked: 1 bit.
- Winner selection (combinational on current inputs):
  - If locked=1 and req[owner]=1 and lock[owner]=1 and bcnt<MAXBURST, the winner is owner.
  - Otherwise the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... wrapping modulo NUMREQ.
  - If req is all zero, there is no winner.
- On a rising edge with a winner w:
  - q<=d_bus word w; gnt<=onehot(w); valid<=1; owner<=w.
  - If w==owner and locked=1: bcnt<=bcnt+1; otherwise bcnt<=1.
  - locked<=lock[w] && (new bcnt < MAXBURST).
  - ptr<=(w+1) mod NUMREQ, so rotation resumes after the burst ends.
- On a rising edge with no winner: q holds; gnt<=0; valid<=0; owner holds; locked<=0; bcnt<=0; ptr holds.
- Latency: data presented with req in cycle n appears on q and gnt after edge n+1. A write takes one cycle; there are no wait states.
- Handshake:
  - A requester holds req and its data stable until it samples its gnt bit high, then changes data or drops req.
  - If req remains high in the cycle gnt is seen, it is a new request and is arbitrated normally.
- Lock released mid-burst (lock[owner] drops): normal round-robin from ptr applies that cycle.
- Burst limit: when bcnt reaches MAXBURST the lock is forced off. The next edge arbitrates round-robin starting at owner+1, even if lock[owner] remains high.
- MAXBURST=1 disables bursting.
- Wrap-around: ptr=NUMREQ-1 followed by a grant to NUMREQ-1 gives ptr=0. When NUMREQ is not a power of two, ptr never takes an index >= NUMREQ.
- Simultaneous requests: exactly one grant; gnt is never multi-hot.
- Reset mid-burst: all state clears; after release the first grant goes to the lowest-index requester at or after 0.

Test Plan:
1. Rst=1 for 40 ns, then 0 with req=0 -> q=0, gnt=0, valid=0, owner=0 throughout.
2. req=4'b0001, d0=10, for one cycle -> next edge: q=10, gnt=0001, valid=1, owner=0. Following idle cycle -> q stays 10, gnt=0, valid=0.
3. req=4'b1111 held, d_i=20+i, lock=0 -> successive q=20,21,22,23,20; gnt rotates 0001,0010,0100,1000,0001.
4. req=4'b0011, lock=4'b0001, MAXBURST=4, d0=30, d1=40 -> q=30 on four consecutive edges, then 40, then 30 again. bcnt never exceeds 4.
5. Repeat scenario 4 but drop lock[0] after two grants -> third grant goes to requester 1 (q=40).
6. Assert Rst asynchronously mid-edge-cycle during scenario 4's burst (second grant) -> q=0, gnt=0 immediately. After release with req=4'b1010 -> first grant to requester 1.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/register bus shared by the write arbiter and its producers
interface reg_write_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int NUMREQ    = 4,
    parameter int IDXW      = 2
);
    logic [NUMREQ-1:0]           req;
    logic [NUMREQ-1:0]           lock;
    logic [NUMREQ*DATAWIDTH-1:0] d_bus;
    logic [DATAWIDTH-1:0]        q;
    logic [NUMREQ-1:0]           gnt;
    logic                        valid;
    logic [IDXW-1:0]             owner;

    modport master (output req, lock, d_bus, input q, gnt, valid, owner);
    modport slave  (input req, lock, d_bus, output q, gnt, valid, owner);
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter with burst locking onto one shared register
module reg_write_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUMREQ    = 4,
    parameter int IDXW      = 2,
    parameter int MAXBURST  = 4
) (
    input logic                Clk,
    input logic                Rst,
    reg_write_arbiter_if.slave bus
);
    logic [DATAWIDTH-1:0] q_q, q_d;
    logic [NUMREQ-1:0]    gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic [IDXW-1:0]      owner_q, owner_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic                 locked_q, locked_d;

    logic                        found;
    logic [IDXW-1:0]             win;
    logic                        hold;
    int                          idx;
    logic [NUMREQ-1:0]           req_sh;
    logic [NUMREQ-1:0]           own_req_sh;
    logic [NUMREQ-1:0]           own_lock_sh;
    logic [NUMREQ-1:0]           win_lock_sh;
    logic [NUMREQ*DATAWIDTH-1:0] d_sh;

    // Locked owner keeps the register until its lock drops or the burst quota is spent.
    always_comb begin
        own_req_sh  = bus.req >> owner_q;
        own_lock_sh = bus.lock >> owner_q;
        hold        = locked_q && own_req_sh[0] && own_lock_sh[0] && (bcnt_q < 4'(MAXBURST));
        found       = 1'b0;
        win         = '0;
        idx         = 0;
        req_sh      = '0;
        if (hold) begin
            found = 1'b1;
            win   = owner_q;
        end else begin
            for (int k = 0; k < NUMREQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUMREQ) idx = idx - NUMREQ;
                req_sh = bus.req >> idx;
                if (!found && req_sh[0]) begin
                    found = 1'b1;
                    win   = IDXW'(idx);
                end
            end
        end
    end

    always_comb begin
        q_d         = q_q;
        gnt_d       = '0;
        valid_d     = 1'b0;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        bcnt_d      = '0;
        locked_d    = 1'b0;
        win_lock_sh = bus.lock >> win;
        d_sh        = bus.d_bus >> (int'(win) * DATAWIDTH);
        if (found) begin
            q_d      = d_sh[DATAWIDTH-1:0];
            gnt_d    = NUMREQ'(1) << win;
            valid_d  = 1'b1;
            owner_d  = win;
            bcnt_d   = (win == owner_q && locked_q) ? bcnt_q + 4'd1 : 4'd1;
            locked_d = win_lock_sh[0] && (bcnt_d < 4'(MAXBURST));
            ptr_d    = (int'(win) == NUMREQ - 1) ? '0 : win + IDXW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q_q      <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
            bcnt_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            bcnt_q   <= bcnt_d;
            locked_q <= locked_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
    assign bus.owner = owner_q;
endmodule
